// File: rtl/base_parity_pkg.sv
// Segment geometry helpers shared by the parity checker.
// Segments are ceil(dwidth/pwidth) bits wide; the last one takes whatever bits remain.
package base_parity_pkg;

  function automatic int seg_width(input int dw, input int pw);
    return (dw + pw - 1) / pw;
  endfunction

  function automatic int seg_lo(input int dw, input int pw, input int idx);
    return idx * seg_width(dw, pw);
  endfunction

  // Clamped to the last data bit so the final (possibly short) segment stays in range.
  function automatic int seg_hi(input int dw, input int pw, input int idx);
    int hi;
    hi = (idx + 1) * seg_width(dw, pw) - 1;
    if (idx == pw - 1 || hi > dw - 1) hi = dw - 1;
    return hi;
  endfunction

endpackage

// File: rtl/base_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear and increment together yield 1.
module base_sat_cnt #(
  parameter int cwidth = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [cwidth-1:0] o_cnt
);

  logic [cwidth-1:0] cnt_reg;
  logic [cwidth-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (i_clr && i_inc)
      cnt_next = {{(cwidth-1){1'b0}}, 1'b1};
    else if (i_clr)
      cnt_next = '0;
    else if (i_inc && (cnt_reg != '1))
      cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end

  assign o_cnt = cnt_reg;

endmodule

// File: rtl/base_parity_chk.sv
// Segmented odd-parity checker: one register stage, sticky error, saturating count, first-error capture.
// Optional one-shot seg-0 error injection via macro BASE_PARITY_CHK_INJ_EN.
module base_parity_chk
  import base_parity_pkg::*;
#(
  parameter int dwidth = 1,
  parameter int pwidth = 1,
  parameter int cwidth = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_v,
  input  logic [0:dwidth-1] i_d,
  input  logic [0:pwidth-1] i_p,
  input  logic              i_err_clr,
`ifdef BASE_PARITY_CHK_INJ_EN
  input  logic              i_inj,
`endif
  output logic              o_v,
  output logic [0:dwidth-1] o_d,
  output logic [0:pwidth-1] o_perr,
  output logic              o_err,
  output logic [cwidth-1:0] o_err_cnt,
  output logic [0:pwidth-1] o_first_perr
);

  logic [0:pwidth-1] p_eff;
  logic [0:pwidth-1] perr_comb;
  logic              beat_err;

  logic              v_reg;
  logic [0:dwidth-1] d_reg;
  logic [0:pwidth-1] perr_reg;
  logic              err_reg;
  logic [0:pwidth-1] first_reg;

`ifdef BASE_PARITY_CHK_INJ_EN
  logic arm_reg;
  logic inj_now;

  // A same-cycle request injects immediately; the arm flag only covers beats that come later.
  assign inj_now = i_v & (arm_reg | i_inj);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      arm_reg <= 1'b0;
    else if (inj_now)
      arm_reg <= 1'b0;
    else if (i_inj)
      arm_reg <= 1'b1;
  end

  always_comb begin
    p_eff    = i_p;
    p_eff[0] = i_p[0] ^ inj_now;
  end
`else
  assign p_eff = i_p;
`endif

  for (genvar gi = 0; gi < pwidth; gi++) begin : g_seg
    localparam int lo = seg_lo(dwidth, pwidth, gi);
    localparam int hi = seg_hi(dwidth, pwidth, gi);
    logic seg_xor;

    always_comb begin
      seg_xor = 1'b0;
      for (int b = 0; b < dwidth; b++)
        if (b >= lo && b <= hi) seg_xor = seg_xor ^ i_d[b];
    end

    // Odd parity: the segment plus its parity bit must XOR to 1.
    assign perr_comb[gi] = ~(seg_xor ^ p_eff[gi]);
  end

  assign beat_err = i_v & (|perr_comb);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      v_reg     <= 1'b0;
      d_reg     <= '0;
      perr_reg  <= '0;
      err_reg   <= 1'b0;
      first_reg <= '0;
    end else begin
      v_reg    <= i_v;
      perr_reg <= i_v ? perr_comb : '0;
      if (i_v) d_reg <= i_d;

      if (beat_err)
        err_reg <= 1'b1;
      else if (i_err_clr)
        err_reg <= 1'b0;

      // A clear in the same cycle makes this beat the first error of the new window.
      if (beat_err && (!err_reg || i_err_clr))
        first_reg <= perr_comb;
      else if (i_err_clr)
        first_reg <= '0;
    end
  end

  base_sat_cnt #(
    .cwidth (cwidth)
  ) u_cnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (i_err_clr),
    .i_inc     (beat_err),
    .o_cnt     (o_err_cnt)
  );

  assign o_v          = v_reg;
  assign o_d          = d_reg;
  assign o_perr       = perr_reg;
  assign o_err        = err_reg;
  assign o_first_perr = first_reg;

endmodule
